// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: FloPoCo exception encodings, 66-bit field offsets,
// the y_writer state encoding and the FloPoCo -> IEEE-754 double conversion.
package spmv_pkg;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } exn_t;

    localparam int FP_EXN_LO = 64;
    localparam int FP_SIGN   = 63;
    localparam int FP_EXP_LO = 52;
    localparam int FP_EXP_W  = 11;
    localparam int FP_FRAC_W = 52;

    localparam logic [63:0] IEEE_QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } yw_state_t;

    // FloPoCo carries specials in the exn field, so the exponent/fraction
    // bits are only meaningful for normals.
    function automatic logic [63:0] flopoco_to_ieee(input logic [65:0] v);
        exn_t exn;
        logic sign;
        exn  = exn_t'(v[FP_EXN_LO +: 2]);
        sign = v[FP_SIGN];
        case (exn)
            EXN_ZERO:   return {sign, 63'b0};
            EXN_NORMAL: return {sign, v[FP_EXP_LO +: FP_EXP_W], v[0 +: FP_FRAC_W]};
            EXN_INF:    return {sign, 11'h7FF, 52'b0};
            default:    return IEEE_QNAN;
        endcase
    endfunction

endpackage

// File: rtl/y_writer_if.sv
// Result-row push port from the intermediator plus the store-request port
// toward the memory controller.
interface y_writer_if #(
    parameter int ADDR_W = 48
);
    logic              push_to_y;
    logic [65:0]       v_to_y;
    logic              eof;
    logic              stall_out;
    logic              mem_req_st;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [63:0]       mem_req_data;
    logic              mem_req_stall;

    modport master (
        output push_to_y, v_to_y, eof, mem_req_stall,
        input  stall_out, mem_req_st, mem_req_addr, mem_req_data
    );

    modport slave (
        input  push_to_y, v_to_y, eof, mem_req_stall,
        output stall_out, mem_req_st, mem_req_addr, mem_req_data
    );
endinterface

// File: rtl/std_fifo.sv
// Synchronous show-ahead FIFO; a write on a full FIFO is accepted when a read
// in the same cycle frees a slot. DEPTH must be a power of 2.
module std_fifo #(
    parameter int WIDTH             = 64,
    parameter int DEPTH             = 32,
    parameter int ALMOST_FULL_COUNT = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    assign rd_ok       = rd_en && !empty;
    assign wr_ok       = wr_en && (!full || rd_ok);
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(ALMOST_FULL_COUNT));
    assign rd_data     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/y_writer.sv
// Buffers converted result-row values and streams them out as sequential
// 64-bit stores at base_addr + 8*i, pulsing done once the run has drained.
module y_writer
    import spmv_pkg::*;
#(
    parameter int FIFO_DEPTH  = 32,
    parameter int ALMOST_FULL = 24,
    parameter int ADDR_W      = 48,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    y_writer_if.slave         bus,
    output logic              done,
    output logic [CNT_W-1:0]  stored_count,
    output logic              overflow_err,
    output logic              protocol_err
);
    yw_state_t         state;
    yw_state_t         state_nxt;
    logic              in_run;
    logic              active;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic [63:0]       wr_data;
    logic [63:0]       rd_data;
    logic              vld_p1;
    logic [63:0]       data_p1;
    logic [ADDR_W-1:0] addr;

    assign in_run  = (state == ST_RUN);
    assign active  = (state == ST_RUN) || (state == ST_DRAIN);
    assign wr_en   = bus.push_to_y && in_run;
    assign wr_data = flopoco_to_ieee(bus.v_to_y);
    assign rd_en   = !empty && !bus.mem_req_stall && active;

    std_fifo #(
        .WIDTH            (64),
        .DEPTH            (FIFO_DEPTH),
        .ALMOST_FULL_COUNT(ALMOST_FULL)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full)
    );

    // DRAIN waits out the registered store so done never precedes it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (bus.eof) state_nxt = ST_DRAIN;
            ST_DRAIN: if (empty && !vld_p1) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            vld_p1       <= 1'b0;
            addr         <= '0;
            stored_count <= '0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= rd_en;
            if (state == ST_IDLE && start) begin
                addr         <= base_addr;
                stored_count <= '0;
            end else if (vld_p1) begin
                addr         <= addr + ADDR_W'(8);
                stored_count <= stored_count + CNT_W'(1);
            end
            if (wr_en && full && !rd_en) overflow_err <= 1'b1;
            if ((bus.push_to_y || bus.eof) && !in_run) protocol_err <= 1'b1;
        end
    end

    // p0 -> p1: popped FIFO head registered as the store payload
    always_ff @(posedge clk) begin
        if (rd_en) data_p1 <= rd_data;
    end

    assign bus.mem_req_st   = vld_p1;
    assign bus.mem_req_addr = addr;
    assign bus.mem_req_data = vld_p1 ? data_p1 : 64'd0;
    assign bus.stall_out    = almost_full;
    assign done             = (state == ST_DONE);

endmodule
